// File: rtl/sdram_read_checker_if.sv
// Read-FIFO bus between the checker (master) and the read FIFO (slave).
interface sdram_read_checker_if #(
  parameter int DATA_W = 16
) ();
  logic              rd_ready;
  logic              sys_rd;
  logic [DATA_W-1:0] sys_data_out;

  modport master (input rd_ready, output sys_rd, input sys_data_out);
  modport slave  (output rd_ready, input sys_rd, output sys_data_out);
endinterface

// File: rtl/sdram_read_checker.sv
// Read-side checker: drains WORDS words from the read FIFO and compares each
// against the incrementing pattern START_VAL+index, reporting pass/fail,
// error statistics, first-mismatch details and read-stall timeout.
module sdram_read_checker #(
  parameter int                DATA_W     = 16,
  parameter int                WORDS      = 512,
  parameter logic [DATA_W-1:0] START_VAL  = {DATA_W{1'b0}},
  parameter int                RD_LATENCY = 1,
  parameter int                TIMEOUT    = 4096
) (
  input  logic                 system_clk,
  input  logic                 sys_rst,
  input  logic                 sdram_init_done,
  input  logic                 start,
  sdram_read_checker_if.master fifo,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [15:0]          err_cnt,
  output logic [15:0]          rx_cnt,
  output logic [15:0]          first_err_idx,
  output logic [DATA_W-1:0]    first_err_data,
  output logic [DATA_W-1:0]    first_err_exp
);

  localparam logic [15:0] WORDS_W16    = 16'(WORDS);
  localparam logic [15:0] LAST_IDX     = 16'(WORDS - 1);
  localparam int          STALL_W      = $clog2(TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_READ      = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [15:0]           issued_r;
  logic [STALL_W-1:0]    stall_r;
  logic [RD_LATENCY-1:0] pipe_r;
  logic                  rd_s;
  logic                  run_start_s;
  logic                  stall_hit_s;
  logic                  strobe_s;
  logic [DATA_W-1:0]     exp_s;

  // Next-state decode, pop request and run start / stall-exit flags.
  always_comb begin
    state_s     = state_r;
    rd_s        = 1'b0;
    run_start_s = 1'b0;
    stall_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s     = ST_WAIT_INIT;
          run_start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_INIT: begin
        if (sdram_init_done) state_s = ST_READ;
        else                 state_s = ST_WAIT_INIT;
      end
      ST_READ: begin
        rd_s = fifo.rd_ready && (issued_r < WORDS_W16);
        if (rd_s && (issued_r == LAST_IDX)) begin
          state_s = ST_DRAIN;
        end else if (!fifo.rd_ready && (stall_r == STALL_LAST)) begin
          state_s     = ST_DONE;
          stall_hit_s = 1'b1;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (rx_cnt == WORDS_W16) state_s = ST_DONE;
        else                     state_s = ST_DRAIN;
      end
      ST_DONE: begin
        if (start) begin
          state_s     = ST_WAIT_INIT;
          run_start_s = 1'b1;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  assign fifo.sys_rd = rd_s;
  // Strobes only count while a run is actually reading; anything left after a timeout is dropped.
  assign strobe_s = pipe_r[RD_LATENCY-1] && ((state_r == ST_READ) || (state_r == ST_DRAIN));
  assign exp_s    = START_VAL + DATA_W'(rx_cnt);

  // FSM state register.
  always_ff @(posedge system_clk) begin
    if (sys_rst) state_r <= ST_IDLE;
    else         state_r <= state_s;
  end

  // Issued-word counter and consecutive rd_ready-low stall counter.
  always_ff @(posedge system_clk) begin
    if (sys_rst) begin
      issued_r <= 16'd0;
      stall_r  <= {STALL_W{1'b0}};
    end else begin
      if (run_start_s) issued_r <= 16'd0;
      else if (rd_s)   issued_r <= issued_r + 16'd1;
      else             issued_r <= issued_r;
      if (state_r != ST_READ)  stall_r <= {STALL_W{1'b0}};
      else if (fifo.rd_ready)  stall_r <= {STALL_W{1'b0}};
      else                     stall_r <= stall_r + STALL_W'(1'b1);
    end
  end

  // Latency pipe: delays each pop by RD_LATENCY cycles to mark valid FIFO data.
  always_ff @(posedge system_clk) begin
    if (sys_rst) begin
      pipe_r <= {RD_LATENCY{1'b0}};
    end else if ((state_r == ST_READ) || (state_r == ST_DRAIN)) begin
      pipe_r[0] <= rd_s;
      for (int i = 1; i < RD_LATENCY; i++) pipe_r[i] <= pipe_r[i-1];
    end else begin
      pipe_r <= {RD_LATENCY{1'b0}};
    end
  end

  // Compare each valid word, count receptions and mismatches, capture the first mismatch.
  always_ff @(posedge system_clk) begin
    if (sys_rst || run_start_s) begin
      err_cnt        <= 16'd0;
      rx_cnt         <= 16'd0;
      first_err_idx  <= 16'd0;
      first_err_data <= {DATA_W{1'b0}};
      first_err_exp  <= {DATA_W{1'b0}};
    end else if (strobe_s) begin
      rx_cnt <= rx_cnt + 16'd1;
      if (fifo.sys_data_out != exp_s) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        else                     err_cnt <= err_cnt;
        if (err_cnt == 16'd0) begin
          first_err_idx  <= rx_cnt;
          first_err_data <= fifo.sys_data_out;
          first_err_exp  <= exp_s;
        end
      end
    end
  end

  // Run status flags: busy from start to finish, verdict latched on entry to DONE.
  always_ff @(posedge system_clk) begin
    if (sys_rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      timeout <= 1'b0;
    end else if (run_start_s) begin
      busy    <= 1'b1;
      done    <= 1'b0;
      pass    <= 1'b0;
      timeout <= 1'b0;
    end else if ((state_r != ST_DONE) && (state_s == ST_DONE)) begin
      busy    <= 1'b0;
      done    <= 1'b1;
      pass    <= (err_cnt == 16'd0) && !stall_hit_s;
      timeout <= stall_hit_s;
    end
  end

endmodule

// File: tb/tb_sdram_read_checker.sv
// Randomized bench for sdram_read_checker: a FIFO model with programmable
// read latency feeds two checker instances (512 words / latency 1 / start 0,
// and 40 words / latency 3 / start FFF0 to exercise pattern wrap).
module tb_sdram_read_checker;

  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_v [2];
  logic        init_v  [2];
  logic        rdy_v   [2];
  logic [15:0] dat_v   [2];
  logic        rd_v    [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic        pass_v  [2];
  logic        to_v    [2];
  logic [15:0] err_v   [2];
  logic [15:0] rx_v    [2];
  logic [15:0] fidx_v  [2];
  logic [15:0] fdat_v  [2];
  logic [15:0] fexp_v  [2];

  logic [15:0] mem [512];
  int total = 0;
  int bad   = 0;

  sdram_read_checker_if #(.DATA_W(16)) ifa ();
  sdram_read_checker_if #(.DATA_W(16)) ifb ();

  assign ifa.rd_ready     = rdy_v[0];
  assign ifa.sys_data_out = dat_v[0];
  assign rd_v[0]          = ifa.sys_rd;
  assign ifb.rd_ready     = rdy_v[1];
  assign ifb.sys_data_out = dat_v[1];
  assign rd_v[1]          = ifb.sys_rd;

  sdram_read_checker #(.DATA_W(16), .WORDS(512), .START_VAL(16'h0000),
                       .RD_LATENCY(1), .TIMEOUT(TMO)) dut_a (
    .system_clk(clk), .sys_rst(rst), .sdram_init_done(init_v[0]), .start(start_v[0]),
    .fifo(ifa), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .timeout(to_v[0]),
    .err_cnt(err_v[0]), .rx_cnt(rx_v[0]), .first_err_idx(fidx_v[0]),
    .first_err_data(fdat_v[0]), .first_err_exp(fexp_v[0]));

  sdram_read_checker #(.DATA_W(16), .WORDS(40), .START_VAL(16'hFFF0),
                       .RD_LATENCY(3), .TIMEOUT(TMO)) dut_b (
    .system_clk(clk), .sys_rst(rst), .sdram_init_done(init_v[1]), .start(start_v[1]),
    .fifo(ifb), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .timeout(to_v[1]),
    .err_cnt(err_v[1]), .rx_cnt(rx_v[1]), .first_err_idx(fidx_v[1]),
    .first_err_data(fdat_v[1]), .first_err_exp(fexp_v[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input int which, input string tag);
    check({tag, "_busy"}, 32'(busy_v[which]), 32'd0);
    check({tag, "_done"}, 32'(done_v[which]), 32'd0);
    check({tag, "_pass"}, 32'(pass_v[which]), 32'd0);
    check({tag, "_timeout"}, 32'(to_v[which]), 32'd0);
    check({tag, "_err"}, 32'(err_v[which]), 32'd0);
    check({tag, "_rx"}, 32'(rx_v[which]), 32'd0);
    check({tag, "_fidx"}, 32'(fidx_v[which]), 32'd0);
    check({tag, "_fdat"}, 32'(fdat_v[which]), 32'd0);
    check({tag, "_fexp"}, 32'(fexp_v[which]), 32'd0);
    check({tag, "_sys_rd"}, 32'(rd_v[which]), 32'd0);
  endtask

  // One check run. stop_at: rd_ready stuck low once that many words were popped.
  // rst_at: pulse sys_rst once that many words were popped (run then abandoned).
  task automatic run(input int which, input int n_corrupt, input int fixed_idx, input int gap_pct,
                     input int gap_at, input int stop_at, input int rst_at, input int init_dly);
    int          words, lat, ptr, cyc, hold, stall_obs, viol, recv, e_err, e_fi;
    logic [15:0] startv, e_fd, e_fe, e;
    logic [15:0] dpipe [4];
    logic        gap_done, rd_now, done_now;
    words  = (which == 0) ? 512 : 40;
    lat    = (which == 0) ? 1 : 3;
    startv = (which == 0) ? 16'h0000 : 16'hFFF0;
    for (int i = 0; i < 512; i++) mem[i] = 16'(int'(startv) + i);
    for (int k = 0; k < n_corrupt; k++) mem[$urandom_range(0, words - 1)] = 16'($urandom);
    if (fixed_idx >= 0) mem[fixed_idx] = 16'hDEAD;
    for (int j = 0; j < 4; j++) dpipe[j] = 16'($urandom);
    ptr = 0; cyc = 0; hold = 0; stall_obs = 0; viol = 0; gap_done = 1'b0;

    @(posedge clk); #1;
    start_v[which] = 1'b1;
    init_v[which]  = (init_dly == 0);
    rdy_v[which]   = 1'b1;
    while (1) begin
      @(negedge clk);
      rd_now   = rd_v[which];
      done_now = done_v[which];
      if (rd_now && !rdy_v[which]) viol++;
      if (cyc > 0 && done_now) break;
      if (ptr >= stop_at) stall_obs++;
      if (cyc > 3000) begin
        check("run_budget_done", 32'(done_now), 32'd1);
        break;
      end
      @(posedge clk); #1;
      for (int j = 3; j > 0; j--) dpipe[j] = dpipe[j-1];
      if (rd_now) begin
        dpipe[0] = mem[ptr];
        ptr++;
      end else begin
        dpipe[0] = 16'($urandom);
      end
      dat_v[which]   = dpipe[lat-1];
      cyc++;
      start_v[which] = (cyc == 20);
      init_v[which]  = (cyc >= init_dly);
      if (rst_at >= 0 && ptr == rst_at) begin
        start_v[which] = 1'b0;
        rdy_v[which]   = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_zero(which, "midrun_reset");
        return;
      end
      if (ptr >= stop_at) begin
        rdy_v[which] = 1'b0;
      end else if (hold > 0) begin
        rdy_v[which] = 1'b0;
        hold--;
      end else if (ptr == gap_at && !gap_done) begin
        gap_done     = 1'b1;
        hold         = 9;
        rdy_v[which] = 1'b0;
      end else begin
        rdy_v[which] = ($urandom_range(0, 99) >= gap_pct);
      end
    end
    start_v[which] = 1'b0;

    // Reference: compare the popped prefix of the FIFO contents with the pattern.
    recv = (stop_at < words) ? stop_at : words;
    e_err = 0; e_fi = 0; e_fd = 16'h0000; e_fe = 16'h0000;
    for (int i = 0; i < recv; i++) begin
      e = 16'(int'(startv) + i);
      if (mem[i] != e) begin
        if (e_err == 0) begin
          e_fi = i; e_fd = mem[i]; e_fe = e;
        end
        e_err++;
      end
    end
    check("done", 32'(done_v[which]), 32'd1);
    check("busy", 32'(busy_v[which]), 32'd0);
    check("pass", 32'(pass_v[which]), 32'((e_err == 0) && (stop_at >= words)));
    check("timeout", 32'(to_v[which]), 32'(stop_at < words));
    check("err_cnt", 32'(err_v[which]), 32'(e_err));
    check("rx_cnt", 32'(rx_v[which]), 32'(recv));
    check("first_err_idx", 32'(fidx_v[which]), 32'(e_fi));
    check("first_err_data", 32'(fdat_v[which]), 32'(e_fd));
    check("first_err_exp", 32'(fexp_v[which]), 32'(e_fe));
    check("sys_rd_count", ptr, recv);
    check("rd_without_ready", viol, 0);
    if (stop_at < words) check("stall_cycles", stall_obs, TMO);
    repeat (3) @(negedge clk);
    check("done_held", 32'(done_v[which]), 32'd1);
    check("rx_held", 32'(rx_v[which]), 32'(recv));
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0; init_v[i] = 1'b0; rdy_v[i] = 1'b0; dat_v[i] = 16'h0000;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_zero(0, "reset_a");
    check_idle_zero(1, "reset_b");

    run(0, 0, -1,   0, -1, 99999, -1, 0);   // clean run
    run(0, 0, 100,  0, -1, 99999, -1, 2);   // word 100 corrupted to DEAD
    run(0, 0, -1,  20, 200, 99999, -1, 3);  // 10-cycle gap at word 200 plus random gaps
    run(0, 0, -1,  10, -1,   300, -1, 1);   // rd_ready stuck low after 300 words
    run(0, 0, -1,   0, -1, 99999, 50, 0);   // reset during READ at word 50
    run(0, 0, -1,   0, -1, 99999, -1, 0);   // clean run after reset
    run(0, 5, -1,  30, -1, 99999, -1, 7);   // random corruptions and gaps
    run(1, 0, -1,  25, -1, 99999, -1, 2);   // wrap FFF0 -> 0000, latency 3
    run(1, 3, -1,  25, 10, 99999, -1, 4);   // wrap with corruptions
    run(1, 0, 18,   0, -1, 99999, -1, 0);   // corrupt word just past the wrap
    run(1, 0, -1,  15, -1,    25, -1, 1);   // latency-3 timeout

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
